tetris_board_renderer: RTL and testbench

Pipelined, fully parametrised successor to the playing-field pixel painter. It maps the VGA raster position to a board cell, picks the cell colour and drives registered RGB with a fixed 2-cycle latency. Cell indices come from raster-tracking counters, so no dividers are used. It adds a frame-timed line-clear flash sequencer with a start/done handshake, which the game FSM uses before collapsing cleared rows. It sits between the game core (board, bricks) and the VGA timing generator.

---
 rtl/tetris_board_renderer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_tetris_board_renderer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_board_renderer.sv
// Paints the playing field from the raster position and flashes rows being cleared.
// Latency: rgb/rgb_valid appear exactly 2 clocks after the pixel is presented.
// No backpressure: the pipeline advances every clock; pix_en only tags valid pixels.
module tetris_board_renderer #(
  parameter int BOARD_W       = 10,
  parameter int BOARD_H       = 20,
  parameter int BLOCK_SIZE    = 20,
  parameter int GAP           = 3,
  parameter int SX            = 200,
  parameter int SY            = 40,
  parameter int FLASH_PERIOD  = 8,
  parameter int FLASH_TOGGLES = 6,
  parameter int ID_W          = $clog2(BOARD_W * BOARD_H)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pix_en,
  input  logic [9:0]                 x_cnt,
  input  logic [9:0]                 y_cnt,
  input  logic                       frame_tick,
  input  logic [BOARD_W*BOARD_H-1:0] board,
  input  logic [2:0]                 cur_type,
  input  logic [4*ID_W-1:0]          cur_cells,
  input  logic [4*ID_W-1:0]          shadow_cells,
  input  logic                       clear_start,
  input  logic [BOARD_H-1:0]         clear_rows,
  output logic                       clear_busy,
  output logic                       clear_done,
  output logic [11:0]                rgb,
  output logic                       rgb_valid
);

  localparam int SUB_W = $clog2(BLOCK_SIZE);
  localparam int COL_W = $clog2(BOARD_W) + 1;
  localparam int ROW_W = $clog2(BOARD_H) + 1;
  localparam int FC_W  = $clog2(FLASH_PERIOD) + 1;
  localparam int TG_W  = $clog2(FLASH_TOGGLES + 1);

  localparam logic [9:0]       X_START = 10'(SX);
  localparam logic [9:0]       Y_START = 10'(SY);
  localparam logic [10:0]      X_LO    = 11'(SX);
  localparam logic [10:0]      X_HI    = 11'(SX + BOARD_W * BLOCK_SIZE);
  localparam logic [10:0]      Y_LO    = 11'(SY);
  localparam logic [10:0]      Y_HI    = 11'(SY + BOARD_H * BLOCK_SIZE);
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(BLOCK_SIZE - 1);
  localparam logic [SUB_W-1:0] GAP_LO  = SUB_W'(GAP);
  localparam logic [SUB_W-1:0] GAP_HI  = SUB_W'(BLOCK_SIZE - GAP);
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FLASH_PERIOD - 1);
  localparam logic [TG_W-1:0]  TG_END  = TG_W'(FLASH_TOGGLES);

  typedef enum logic {S_IDLE, S_FLASH} state_t;

  // Raster trackers: *_q hold the values for the next pixel on this line (x)
  // and for the current line (y).
  logic [SUB_W-1:0] x_sub_q, x_sub_cur, x_sub_nxt;
  logic [COL_W-1:0] x_col_q, x_col_cur, x_col_nxt;
  logic [SUB_W-1:0] y_sub_q, y_sub_adv, y_sub_cur;
  logic [ROW_W-1:0] y_row_q, y_row_adv, y_row_cur;
  logic             line_start;

  // Stage 1 decode
  logic             in_board, in_gap, flash_hit;
  logic [ROW_W-1:0] brow;
  logic [ID_W-1:0]  cell_id;
  logic             s1_vld, s1_draw, s1_flash;
  logic [ID_W-1:0]  s1_id;

  // Stage 2 colour
  logic             cur_hit, sh_hit;
  logic [11:0]      pal_rgb, colour;

  // Flash sequencer
  state_t            state_q, state_d;
  logic [BOARD_H-1:0] mask_q, mask_d;
  logic [FC_W-1:0]   frame_q, frame_d;
  logic [TG_W-1:0]   tog_q, tog_d;
  logic              phase_q, phase_d;
  logic              done_q, done_d;
  logic              flash_on;

  assign line_start = (x_cnt == 10'd0);

  // Current cell coordinates derived from the counters, with resyncs at the board edges.
  always_comb begin
    x_sub_cur = x_sub_q;
    x_col_cur = x_col_q;
    if (x_cnt == X_START) begin
      x_sub_cur = '0;
      x_col_cur = '0;
    end
    x_sub_nxt = x_sub_cur + 1'b1;
    x_col_nxt = x_col_cur;
    if (x_sub_cur == SUB_MAX) begin
      x_sub_nxt = '0;
      x_col_nxt = x_col_cur + 1'b1;
    end

    y_sub_adv = y_sub_q + 1'b1;
    y_row_adv = y_row_q;
    if (y_sub_q == SUB_MAX) begin
      y_sub_adv = '0;
      y_row_adv = y_row_q + 1'b1;
    end
    if (y_cnt == Y_START) begin
      y_sub_adv = '0;
      y_row_adv = '0;
    end
    y_sub_cur = line_start ? y_sub_adv : y_sub_q;
    y_row_cur = line_start ? y_row_adv : y_row_q;
  end

  // Advance the trackers on every visible pixel; the row trackers step once per line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_sub_q <= '0;
      x_col_q <= '0;
      y_sub_q <= '0;
      y_row_q <= '0;
    end else if (pix_en) begin
      x_sub_q <= x_sub_nxt;
      x_col_q <= x_col_nxt;
      if (line_start) begin
        y_sub_q <= y_sub_cur;
        y_row_q <= y_row_cur;
      end
    end
  end

  // Board window, cell border, cell id and flash hit for the pixel being presented.
  always_comb begin
    in_board = ({1'b0, x_cnt} >= X_LO) && ({1'b0, x_cnt} < X_HI) &&
               ({1'b0, y_cnt} >= Y_LO) && ({1'b0, y_cnt} < Y_HI);
    in_gap   = (x_sub_cur < GAP_LO) || (x_sub_cur >= GAP_HI) ||
               (y_sub_cur < GAP_LO) || (y_sub_cur >= GAP_HI);
    // Screen rows count downward, board rows count upward from the bottom.
    brow     = ROW_W'(BOARD_H - 1) - y_row_cur;
    cell_id  = ID_W'(brow) * ID_W'(BOARD_W) + ID_W'(x_col_cur);
    flash_hit = 1'b0;
    for (int r = 0; r < BOARD_H; r++) begin
      if (brow == ROW_W'(r)) flash_hit = mask_q[r];
    end
    flash_hit = flash_hit && flash_on && in_board;
  end

  // Stage 1 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_draw  <= 1'b0;
      s1_flash <= 1'b0;
      s1_id    <= '0;
    end else begin
      s1_vld   <= pix_en;
      s1_draw  <= in_board && !in_gap;
      s1_flash <= flash_hit;
      s1_id    <= cell_id;
    end
  end

  // Colour selection in priority order: flash, brick, shadow, filled, empty.
  always_comb begin
    cur_hit = 1'b0;
    sh_hit  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (cur_cells[k*ID_W +: ID_W] == s1_id)    cur_hit = 1'b1;
      if (shadow_cells[k*ID_W +: ID_W] == s1_id) sh_hit  = 1'b1;
    end
    case (cur_type)
      3'd1:    pal_rgb = 12'hF00;
      3'd2:    pal_rgb = 12'h00F;
      3'd3:    pal_rgb = 12'hF90;
      3'd4:    pal_rgb = 12'hFF0;
      3'd5:    pal_rgb = 12'hF0F;
      3'd6:    pal_rgb = 12'h0FF;
      3'd7:    pal_rgb = 12'h0F0;
      default: pal_rgb = 12'h000;
    endcase
    colour = 12'h000;
    if (s1_draw) begin
      if (s1_flash)          colour = 12'hFFF;
      else if (cur_hit)      colour = pal_rgb;
      else if (sh_hit)       colour = 12'h777;
      else if (board[s1_id]) colour = 12'h720;
      else                   colour = 12'hACA;
    end
  end

  // Stage 2 register: drives the RGB outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb       <= 12'h000;
      rgb_valid <= 1'b0;
    end else begin
      rgb       <= colour;
      rgb_valid <= s1_vld;
    end
  end

  assign flash_on   = (state_q == S_FLASH) && phase_q;
  assign clear_busy = (state_q == S_FLASH);
  assign clear_done = done_q;

  // Flash sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      frame_q <= '0;
      tog_q   <= '0;
      phase_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      frame_q <= frame_d;
      tog_q   <= tog_d;
      phase_q <= phase_d;
      done_q  <= done_d;
    end
  end

  // Flash sequencer next state: counts frames per phase and phases per sequence.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    frame_d = frame_q;
    tog_d   = tog_q;
    phase_d = phase_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clear_start) begin
          if (|clear_rows) begin
            mask_d  = clear_rows;
            phase_d = 1'b1;
            frame_d = '0;
            tog_d   = '0;
            state_d = S_FLASH;
          end else begin
            // Nothing to flash: acknowledge straight away.
            done_d = 1'b1;
          end
        end
      end
      S_FLASH: begin
        if (frame_tick) begin
          if (frame_q == FC_LAST) begin
            frame_d = '0;
            phase_d = !phase_q;
            tog_d   = tog_q + 1'b1;
            if (tog_q + 1'b1 == TG_END) begin
              done_d  = 1'b1;
              phase_d = 1'b0;
              state_d = S_IDLE;
            end
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tetris_board_renderer.sv
module tb_tetris_board_renderer;

  localparam int W   = 10;
  localparam int H   = 20;
  localparam int BS  = 20;
  localparam int GAP = 3;
  localparam int SX  = 200;
  localparam int SY  = 40;
  localparam int P   = 8;
  localparam int T   = 6;
  localparam int IDW = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           pix_en;
  logic [9:0]     x_cnt, y_cnt;
  logic           frame_tick;
  logic [W*H-1:0] board;
  logic [2:0]     cur_type;
  logic [4*IDW-1:0] cur_cells, shadow_cells;
  logic           clear_start;
  logic [H-1:0]   clear_rows;
  logic           clear_busy, clear_done;
  logic [11:0]    rgb;
  logic           rgb_valid;

  logic [IDW-1:0] cur_id [4];
  logic [IDW-1:0] sh_id  [4];
  assign cur_cells    = {cur_id[3], cur_id[2], cur_id[1], cur_id[0]};
  assign shadow_cells = {sh_id[3], sh_id[2], sh_id[1], sh_id[0]};

  tetris_board_renderer #(
    .BOARD_W(W), .BOARD_H(H), .BLOCK_SIZE(BS), .GAP(GAP), .SX(SX), .SY(SY),
    .FLASH_PERIOD(P), .FLASH_TOGGLES(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x_cnt(x_cnt), .y_cnt(y_cnt),
    .frame_tick(frame_tick), .board(board), .cur_type(cur_type),
    .cur_cells(cur_cells), .shadow_cells(shadow_cells),
    .clear_start(clear_start), .clear_rows(clear_rows),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .rgb(rgb), .rgb_valid(rgb_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expected colour and issue cycle for every valid pixel.
  logic [11:0] sb_rgb [$];
  int          sb_cyc [$];

  // Reference model of the flash sequence.
  bit         m_busy, m_done;
  int         m_ticks;
  logic [H-1:0] m_mask;
  bit         ft_en;
  int         tick_div;
  bit         sel_line [0:511];

  logic [11:0] pal [0:7] = '{12'h000, 12'hF00, 12'h00F, 12'hF90,
                             12'hFF0, 12'hF0F, 12'h0FF, 12'h0F0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] model_rgb(input logic [9:0] x, input logic [9:0] y);
    int dx, dy, col, brow, id;
    dx = int'(x) - SX;
    dy = int'(y) - SY;
    if (dx < 0 || dx >= W*BS || dy < 0 || dy >= H*BS) return 12'h000;
    if ((dx % BS) < GAP || (dx % BS) >= BS-GAP || (dy % BS) < GAP || (dy % BS) >= BS-GAP)
      return 12'h000;
    col  = dx / BS;
    brow = H - 1 - dy / BS;
    id   = brow * W + col;
    if (m_busy && ((m_ticks / P) % 2 == 0) && m_mask[brow]) return 12'hFFF;
    for (int k = 0; k < 4; k++) if (int'(cur_id[k]) == id) return pal[cur_type];
    for (int k = 0; k < 4; k++) if (int'(sh_id[k]) == id) return 12'h777;
    if (board[id]) return 12'h720;
    return 12'hACA;
  endfunction

  function automatic void model_step(input logic ft, input logic cs, input logic [H-1:0] rows);
    m_done = 0;
    if (m_busy) begin
      if (ft) begin
        m_ticks++;
        if (m_ticks == P*T) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end else if (cs) begin
      if (rows != 0) begin
        m_busy  = 1;
        m_mask  = rows;
        m_ticks = 0;
      end else begin
        m_done = 1;
      end
    end
  endfunction

  // One clock of stimulus; called just after a rising edge.
  task automatic drive(input logic pe, input logic [9:0] x, input logic [9:0] y,
                       input logic cs, input logic [H-1:0] rows);
    logic ft;
    ft = ft_en && (tick_div == 9);
    tick_div = (tick_div == 9) ? 0 : tick_div + 1;
    pix_en = pe; x_cnt = x; y_cnt = y;
    frame_tick = ft; clear_start = cs; clear_rows = rows;
    if (pe) begin
      sb_rgb.push_back(model_rgb(x, y));
      sb_cyc.push_back(cyc);
    end
    @(posedge clk);
    model_step(ft, cs, rows);
    #1;
    chk("clear_busy", 32'(clear_busy), 32'(m_busy));
    chk("clear_done", 32'(clear_done), 32'(m_done));
  endtask

  task automatic drain();
    repeat (3) drive(1'b0, x_cnt, y_cnt, 1'b0, '0);
  endtask

  // Raster pass from just above the board down to y_last; selected lines get a pixel span.
  task automatic pass(input int y_last, input int x_lo, input int x_hi);
    for (int y = SY-1; y <= y_last; y++) begin
      drive(1'b1, 10'd0, 10'(y), 1'b0, '0);
      if (sel_line[y]) begin
        for (int x = x_lo; x <= x_hi; x++) begin
          if ($urandom_range(0, 7) == 0) drive(1'b0, 10'(x), 10'(y), 1'b0, '0);
          drive(1'b1, 10'(x), 10'(y), 1'b0, '0);
        end
      end
    end
  endtask

  task automatic clear_sel();
    for (int i = 0; i < 512; i++) sel_line[i] = 0;
  endtask

  task automatic rand_scene();
    for (int i = 0; i < W*H; i++) board[i] = 1'($urandom_range(0, 1));
    for (int k = 0; k < 4; k++) begin
      cur_id[k] = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom_range(0, W*H-1));
      sh_id[k]  = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom_range(0, W*H-1));
    end
    cur_type = 3'($urandom_range(1, 7));
  endtask

  // Flash sequence observed on bottom-row pixels; abort_at>0 stops at that tick count.
  task automatic flash_run(input logic [H-1:0] rows, input int abort_at);
    int guard;
    bit sent2, cs2, stop;
    int yy;
    yy = SY + (H-1)*BS + 10;
    clear_sel();
    pass(yy, 0, 0);
    tick_div = 9;  // frame_tick lands on the same cycle as clear_start
    drive(1'b0, 10'(SX+10), 10'(yy), 1'b1, rows);
    guard = 0; sent2 = 0; stop = 0;
    while (m_busy && guard < 4000 && !stop) begin
      for (int x = SX-2; x <= SX+41; x++) begin
        cs2 = (abort_at == 0) && !sent2 && (m_ticks == 5);
        if (cs2) sent2 = 1;
        drive(1'b1, 10'(x), 10'(yy), cs2, cs2 ? 20'hFFFFE : 20'h0);
        guard++;
        stop = (abort_at > 0) && (m_ticks >= abort_at);
        if (!m_busy || stop) break;
      end
    end
    chk("flash_timeout", 32'(guard >= 4000), 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pixel.
  logic [11:0] mon_e;
  int          mon_c;
  always @(negedge clk) begin
    if (rst_n && rgb_valid) begin
      if (sb_rgb.size() == 0) begin
        chk("unexpected_valid", 32'(rgb), 32'hFFFFFFFF);
      end else begin
        mon_e = sb_rgb.pop_front();
        mon_c = sb_cyc.pop_front();
        chk("rgb", 32'(rgb), 32'(mon_e));
        chk("latency", 32'(cyc - mon_c), 32'd2);
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    pix_en = 0; x_cnt = 0; y_cnt = 0; frame_tick = 0;
    board = '0; cur_type = 3'd1; clear_start = 0; clear_rows = '0;
    for (int k = 0; k < 4; k++) begin cur_id[k] = 8'hFF; sh_id[k] = 8'hFF; end
    m_busy = 0; m_done = 0; m_ticks = 0; m_mask = '0; ft_en = 0; tick_div = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rgb", 32'(rgb), 32'h0);
    chk("reset_valid", 32'(rgb_valid), 32'h0);
    chk("reset_busy", 32'(clear_busy), 32'h0);
    chk("reset_done", 32'(clear_done), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Empty board, no brick.
    clear_sel();
    sel_line[SY-1] = 1; sel_line[45] = 1; sel_line[50] = 1; sel_line[430] = 1; sel_line[SY+H*BS] = 1;
    pass(SY + H*BS, SX-2, SX + W*BS + 1);
    drain();

    // Filled top-left cell, brick over bottom-left cell.
    board[190] = 1'b1; cur_id[0] = 8'd0; cur_type = 3'd3;
    clear_sel(); sel_line[50] = 1; sel_line[430] = 1;
    pass(SY + H*BS, SX-2, SX + W*BS + 1);
    drain();

    // Brick and shadow overlap; shadow over a filled cell.
    board = '0; board[6] = 1'b1;
    cur_id[0] = 8'd5; sh_id[0] = 8'd5; sh_id[1] = 8'd6; cur_type = 3'd5;
    clear_sel(); sel_line[430] = 1; sel_line[431] = 1;
    pass(SY + H*BS, SX-2, SX + W*BS + 1);
    drain();

    // Randomised sweeps touching every board row and column.
    for (int p = 0; p < 3; p++) begin
      rand_scene();
      clear_sel();
      sel_line[SY-1] = 1; sel_line[SY+H*BS] = 1;
      for (int r = 0; r < H; r++) sel_line[SY + r*BS + (r*7 + p*3) % BS] = 1;
      pass(SY + H*BS, SX-2, SX + W*BS + 1);
      drain();
    end

    // Full flash sequence on row 0 with an ignored second start.
    rand_scene();
    ft_en = 1;
    flash_run(20'h00001, 0);
    drain();

    // Empty mask: immediate done, no busy.
    drive(1'b0, 10'(SX+10), y_cnt, 1'b1, 20'h0);
    drive(1'b0, 10'(SX+10), y_cnt, 1'b0, 20'h0);

    // Reset in the middle of a flash.
    flash_run(20'h00001, 20);
    drain();
    frame_tick = 0; clear_start = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(clear_busy), 32'h0);
    chk("abort_rgb", 32'(rgb), 32'h0);
    chk("abort_valid", 32'(rgb_valid), 32'h0);
    chk("abort_done", 32'(clear_done), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    m_busy = 0; m_done = 0; m_ticks = 0; m_mask = '0; tick_div = 0;
    @(posedge clk); #1;
    chk("post_reset_busy", 32'(clear_busy), 32'h0);
    chk("post_reset_done", 32'(clear_done), 32'h0);
    flash_run(20'h00001, 0);
    drain();
    ft_en = 0;
    drain();

    chk("scoreboard_empty", 32'(sb_rgb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
